// File: rtl/map_color_stream_pkg.sv
// Shared types and sizing helpers for the map-colouring validator.
package map_color_pkg;

    typedef enum logic [1:0] {
        LOAD,
        CHECK,
        REPORT
    } state_e;

    // Oz map: 0=GC 1=WC 2=QC 3=MC 4=EC, bit[i*5+j] set when i<j are adjacent.
    localparam logic [24:0] OZ_ADJ = 25'h008629A;

    function automatic int npairs(input int n);
        return n * (n - 1) / 2;
    endfunction

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_w(input int n);
        return $clog2(npairs(n) + 1);
    endfunction

endpackage

// File: rtl/map_color_stream_if.sv
// Colour input stream and verdict output stream of the validator.
interface map_color_stream_if #(
    parameter int NREGIONS = 5,
    parameter int CBITS    = 2
) ();
    localparam int CW = map_color_pkg::cnt_w(NREGIONS);
    localparam int IW = map_color_pkg::idx_w(NREGIONS);

    logic             in_valid;
    logic             in_ready;
    logic [CBITS-1:0] in_color;
    logic             out_valid;
    logic             out_ready;
    logic             out_ok;
    logic             out_range_err;
    logic [CW-1:0]    out_nconf;
    logic [IW-1:0]    out_first_a;
    logic [IW-1:0]    out_first_b;

    modport master (
        output in_valid, in_color, out_ready,
        input  in_ready, out_valid, out_ok, out_range_err,
               out_nconf, out_first_a, out_first_b
    );

    modport slave (
        input  in_valid, in_color, out_ready,
        output in_ready, out_valid, out_ok, out_range_err,
               out_nconf, out_first_a, out_first_b
    );
endinterface

// File: rtl/map_color_stream_walker.sv
// Row-major iterator over region pairs (i,j), i<j. Parks on the last pair
// until start reloads (0,1).
module map_pair_walker
    import map_color_pkg::*;
#(
    parameter int NREGIONS = 5,
    localparam int IW      = idx_w(NREGIONS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic [IW-1:0] i,
    output logic [IW-1:0] j,
    output logic          last
);
    localparam logic [IW-1:0] LAST_I = IW'(NREGIONS - 2);
    localparam logic [IW-1:0] LAST_J = IW'(NREGIONS - 1);

    logic [IW-1:0] i_q, i_d;
    logic [IW-1:0] j_q, j_d;

    assign last = (i_q == LAST_I) && (j_q == LAST_J);
    assign i    = i_q;
    assign j    = j_q;

    // Next pair: advance j, wrap to the next row at the end of a row.
    always_comb begin
        i_d = i_q;
        j_d = j_q;
        if (start) begin
            i_d = '0;
            j_d = IW'(1);
        end else if (!last) begin
            if (j_q == LAST_J) begin
                i_d = i_q + IW'(1);
                j_d = i_q + IW'(2);
            end else begin
                j_d = j_q + IW'(1);
            end
        end
    end

    // Pair registers; reset parks on the last pair so the walker stays idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q <= LAST_I;
            j_q <= LAST_J;
        end else begin
            i_q <= i_d;
            j_q <= j_d;
        end
    end
endmodule

// File: rtl/map_color_stream.sv
// Map-colouring validator: loads one colour per region, walks every pair
// once against the adjacency mask and reports the verdict.
module map_color_stream
    import map_color_pkg::*;
#(
    parameter int NREGIONS                        = 5,
    parameter int CBITS                           = 2,
    parameter int NCOLORS                         = 4,
    parameter logic [NREGIONS*NREGIONS-1:0] ADJ   = OZ_ADJ
) (
    input logic               clk,
    input logic               rst_n,
    map_color_stream_if.slave bus
);
    localparam int IW = idx_w(NREGIONS);
    localparam int CW = cnt_w(NREGIONS);
    localparam int AW = $clog2(NREGIONS * NREGIONS);
    localparam logic [NREGIONS*NREGIONS-1:0] ADJ_V = ADJ;

    state_e        state_q;
    logic [IW-1:0] idx_q;
    logic          range_q;
    logic [CW-1:0] nconf_q, nconf_d;
    logic [IW-1:0] fa_q, fb_q;
    logic          hit_q, hv_q, drain_q;
    logic [IW-1:0] ha_q, hb_q;
    logic          in_ready_q, out_valid_q, ok_q;
    logic [CBITS-1:0] col_q [NREGIONS];

    logic [IW-1:0] wi, wj;
    logic          wlast;
    logic          accept, load_last, bad_color, pair_hit, acc;
    logic [AW-1:0] adj_idx;

    map_pair_walker #(.NREGIONS(NREGIONS)) u_walker (
        .clk   (clk),
        .rst_n (rst_n),
        .start (load_last),
        .i     (wi),
        .j     (wj),
        .last  (wlast)
    );

    // Input acceptance, range test and registered pair comparison term.
    always_comb begin
        accept    = (state_q == LOAD) && in_ready_q && bus.in_valid;
        load_last = accept && (idx_q == IW'(NREGIONS - 1));
        bad_color = ({1'b0, bus.in_color} >= (CBITS+1)'(NCOLORS));
        adj_idx   = AW'(wi) * AW'(NREGIONS) + AW'(wj);
        pair_hit  = ADJ_V[adj_idx] && (col_q[wi] == col_q[wj]);
        acc       = hv_q && hit_q;
        nconf_d   = nconf_q + CW'(acc);
    end

    // Colour file, written only by accepted beats; no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            col_q[idx_q] <= bus.in_color;
        end
    end

    // Control FSM. The pair compare is registered and accumulated one cycle
    // later, so CHECK ends with a single drain cycle after the last pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            idx_q       <= '0;
            range_q     <= 1'b0;
            nconf_q     <= '0;
            fa_q        <= '0;
            fb_q        <= '0;
            hit_q       <= 1'b0;
            hv_q        <= 1'b0;
            drain_q     <= 1'b0;
            ha_q        <= '0;
            hb_q        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            ok_q        <= 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (accept) begin
                        range_q <= range_q | bad_color;
                        if (load_last) begin
                            state_q    <= CHECK;
                            idx_q      <= '0;
                            in_ready_q <= 1'b0;
                            hv_q       <= 1'b0;
                            drain_q    <= 1'b0;
                            nconf_q    <= '0;
                            fa_q       <= '0;
                            fb_q       <= '0;
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end
                end
                CHECK: begin
                    nconf_q <= nconf_d;
                    if (acc && (nconf_q == '0)) begin
                        fa_q <= ha_q;
                        fb_q <= hb_q;
                    end
                    if (drain_q) begin
                        state_q     <= REPORT;
                        out_valid_q <= 1'b1;
                        ok_q        <= (nconf_d == '0) && !range_q;
                        hv_q        <= 1'b0;
                        drain_q     <= 1'b0;
                    end else begin
                        hit_q   <= pair_hit;
                        ha_q    <= wi;
                        hb_q    <= wj;
                        hv_q    <= 1'b1;
                        drain_q <= wlast;
                    end
                end
                REPORT: begin
                    if (bus.out_ready) begin
                        state_q     <= LOAD;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                        ok_q        <= 1'b0;
                        idx_q       <= '0;
                        range_q     <= 1'b0;
                        nconf_q     <= '0;
                        fa_q        <= '0;
                        fb_q        <= '0;
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_ok        = ok_q;
    assign bus.out_range_err = range_q;
    assign bus.out_nconf     = nconf_q;
    assign bus.out_first_a   = fa_q;
    assign bus.out_first_b   = fb_q;
endmodule

// File: tb/tb_map_color_stream.sv
// Scoreboard bench: two N=5 instances (NCOLORS 4 and 3) share one stimulus
// stream; an N=8 instance runs random frames against a reference model.
module tb_map_color_stream;
    localparam logic [63:0] ADJ8 = 64'h9D3B_6E15_C7A2_48F9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       v5, r5, v8, r8;
    logic [1:0] c5;
    logic [2:0] c8;

    map_color_stream_if #(.NREGIONS(5), .CBITS(2)) if_a ();
    map_color_stream_if #(.NREGIONS(5), .CBITS(2)) if_b ();
    map_color_stream_if #(.NREGIONS(8), .CBITS(3)) if_c ();

    assign if_a.in_valid  = v5;
    assign if_a.in_color  = c5;
    assign if_a.out_ready = r5;
    assign if_b.in_valid  = v5;
    assign if_b.in_color  = c5;
    assign if_b.out_ready = r5;
    assign if_c.in_valid  = v8;
    assign if_c.in_color  = c8;
    assign if_c.out_ready = r8;

    map_color_stream #(.NREGIONS(5), .CBITS(2), .NCOLORS(4), .ADJ(25'h008629A)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a.slave));
    map_color_stream #(.NREGIONS(5), .CBITS(2), .NCOLORS(3), .ADJ(25'h008629A)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b.slave));
    map_color_stream #(.NREGIONS(8), .CBITS(3), .NCOLORS(5), .ADJ(ADJ8)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(if_c.slave));

    typedef struct {
        int ok;
        int rerr;
        int nconf;
        int fa;
        int fb;
    } exp_t;

    exp_t qa[$], qb[$], qc[$];
    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input int ok, input int rerr, input int nconf, input int fa, input int fb);
        exp_t e;
        e.ok = ok; e.rerr = rerr; e.nconf = nconf; e.fa = fa; e.fb = fb;
        return e;
    endfunction

    // Reference verdict from first principles over packed 3-bit colour fields.
    function automatic exp_t model(input int n, input logic [63:0] adj, input int ncol,
                                   input logic [23:0] cols);
        exp_t e;
        e = mk(0, 0, 0, 0, 0);
        for (int k = 0; k < n; k++)
            if (int'(cols[3*k +: 3]) >= ncol) e.rerr = 1;
        for (int a = 0; a < n; a++)
            for (int b = a + 1; b < n; b++)
                if (adj[a*n + b] && cols[3*a +: 3] == cols[3*b +: 3]) begin
                    if (e.nconf == 0) begin e.fa = a; e.fb = b; end
                    e.nconf++;
                end
        e.ok = (e.nconf == 0 && e.rerr == 0) ? 1 : 0;
        return e;
    endfunction

    function automatic logic [9:0] pk5(input int c0, input int c1, input int c2, input int c3, input int c4);
        return {c4[1:0], c3[1:0], c2[1:0], c1[1:0], c0[1:0]};
    endfunction

    // Verdict monitors: a handshake happens at the next rising edge.
    exp_t ea, eb, ec;
    always @(negedge clk) begin
        if (rst_n === 1'b1 && if_a.out_valid === 1'b1 && r5 === 1'b1) begin
            if (qa.size() == 0) check_val("a_spurious", 1, 0);
            else begin
                ea = qa.pop_front();
                check_val("a_ok", if_a.out_ok, ea.ok);
                check_val("a_rerr", if_a.out_range_err, ea.rerr);
                check_val("a_nconf", if_a.out_nconf, ea.nconf);
                check_val("a_first_a", if_a.out_first_a, ea.fa);
                check_val("a_first_b", if_a.out_first_b, ea.fb);
            end
        end
        if (rst_n === 1'b1 && if_b.out_valid === 1'b1 && r5 === 1'b1) begin
            if (qb.size() == 0) check_val("b_spurious", 1, 0);
            else begin
                eb = qb.pop_front();
                check_val("b_ok", if_b.out_ok, eb.ok);
                check_val("b_rerr", if_b.out_range_err, eb.rerr);
                check_val("b_nconf", if_b.out_nconf, eb.nconf);
                check_val("b_first_a", if_b.out_first_a, eb.fa);
                check_val("b_first_b", if_b.out_first_b, eb.fb);
            end
        end
        if (rst_n === 1'b1 && if_c.out_valid === 1'b1 && r8 === 1'b1) begin
            if (qc.size() == 0) check_val("c_spurious", 1, 0);
            else begin
                ec = qc.pop_front();
                check_val("c_ok", if_c.out_ok, ec.ok);
                check_val("c_rerr", if_c.out_range_err, ec.rerr);
                check_val("c_nconf", if_c.out_nconf, ec.nconf);
                check_val("c_first_a", if_c.out_first_a, ec.fa);
                check_val("c_first_b", if_c.out_first_b, ec.fb);
            end
        end
    end

    task automatic send5(input logic [9:0] cols, input int nb, input int gap);
        int n;
        for (int k = 0; k < nb; k++) begin
            if (gap > 0) begin
                v5 = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
            v5 = 1'b1;
            c5 = cols[2*k +: 2];
            n = 0;
            while (if_a.in_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
            if (n >= 50) check_val("a_in_ready_timeout", 0, 1);
            @(posedge clk); #1;
        end
        v5 = 1'b0;
    endtask

    task automatic send8(input logic [23:0] cols);
        int n;
        for (int k = 0; k < 8; k++) begin
            v8 = 1'b1;
            c8 = cols[3*k +: 3];
            n = 0;
            while (if_c.in_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
            if (n >= 50) check_val("c_in_ready_timeout", 0, 1);
            @(posedge clk); #1;
        end
        v8 = 1'b0;
    endtask

    task automatic drain5();
        int n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin @(posedge clk); #1; n++; end
        check_val("drain5_pending", qa.size() + qb.size(), 0);
    endtask

    task automatic frame5(input logic [9:0] cols, input exp_t xa, input exp_t xb);
        qa.push_back(xa);
        qb.push_back(xb);
        send5(cols, 5, 0);
        drain5();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        logic [23:0] cols8;
        int dly;
        rst_n = 1'b0;
        v5 = 1'b0; c5 = '0; r5 = 1'b0;
        v8 = 1'b0; c8 = '0; r8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_out_valid", if_a.out_valid, 0);
        check_val("rst_in_ready", if_a.in_ready, 1);
        check_val("rst_ok", if_a.out_ok, 0);
        check_val("rst_nconf", if_a.out_nconf, 0);
        check_val("rst_rerr", if_a.out_range_err, 0);
        check_val("rst_first_a", if_a.out_first_a, 0);
        check_val("rst_first_b", if_a.out_first_b, 0);
        check_val("rst_c_out_valid", if_c.out_valid, 0);
        check_val("rst_c_in_ready", if_c.in_ready, 1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        r5 = 1'b1;

        // Legal colouring, with the fixed latency measured from the last beat.
        qa.push_back(mk(1, 0, 0, 0, 0));
        qb.push_back(mk(1, 0, 0, 0, 0));
        send5(pk5(0, 1, 0, 1, 2), 5, 0);
        n = 0;
        while (if_a.out_valid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        check_val("latency", n, 11);
        drain5();

        // All equal, two adjacent conflicts, and a colour outside NCOLORS=3.
        frame5(pk5(0, 0, 0, 0, 0), mk(0, 0, 8, 0, 1), mk(0, 0, 8, 0, 1));
        frame5(pk5(0, 1, 0, 1, 1), mk(0, 0, 2, 1, 4), mk(0, 0, 2, 1, 4));
        frame5(pk5(0, 1, 0, 1, 3), mk(1, 0, 0, 0, 0), mk(0, 1, 0, 0, 0));

        // Backpressure: gappy input, verdict held 20 cycles, in_valid ignored.
        r5 = 1'b0;
        qa.push_back(mk(0, 0, 2, 0, 3));
        qb.push_back(mk(0, 0, 2, 0, 3));
        send5(pk5(0, 1, 2, 0, 1), 5, 2);
        n = 0;
        while (if_a.out_valid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        check_val("bp_valid_timeout", if_a.out_valid, 1);
        v5 = 1'b1;
        c5 = 2'd3;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            check_val("bp_hold_valid", if_a.out_valid, 1);
            check_val("bp_hold_in_ready", if_a.in_ready, 0);
            check_val("bp_hold_nconf", if_a.out_nconf, 2);
            check_val("bp_hold_first_b", if_a.out_first_b, 3);
        end
        v5 = 1'b0;
        r5 = 1'b1;
        @(posedge clk); #1;
        check_val("bp_released", if_a.out_valid, 0);
        check_val("bp_load_ready", if_a.in_ready, 1);
        frame5(pk5(3, 3, 3, 3, 3), mk(0, 0, 8, 0, 1), mk(0, 1, 8, 0, 1));

        // Reset in the middle of the edge walk.
        send5(pk5(0, 0, 0, 0, 0), 5, 0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("abort_out_valid", if_a.out_valid, 0);
        check_val("abort_in_ready", if_a.in_ready, 1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        frame5(pk5(1, 0, 2, 0, 3), mk(1, 0, 0, 0, 0), mk(0, 1, 0, 0, 0));

        // Reset after a partial frame: next beat must be region 0.
        send5(pk5(1, 1, 0, 0, 0), 2, 0);
        rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        frame5(pk5(2, 1, 2, 0, 2), mk(0, 0, 2, 0, 4), mk(0, 0, 2, 0, 4));

        // N=8 random frames with random verdict backpressure.
        for (int f = 0; f < 1000; f++) begin
            int mode;
            mode = int'($urandom_range(0, 3));
            cols8 = '0;
            for (int k = 0; k < 8; k++) begin
                logic [2:0] cv;
                if ($urandom_range(0, 15) == 0) cv = 3'($urandom_range(5, 7));
                else if (mode == 0) cv = 3'($urandom_range(0, 4));
                else cv = 3'($urandom_range(0, 3));
                cols8[3*k +: 3] = cv;
            end
            qc.push_back(model(8, ADJ8, 5, cols8));
            r8 = 1'b0;
            send8(cols8);
            dly = int'($urandom_range(0, 35));
            repeat (dly) @(posedge clk);
            #1;
            r8 = 1'b1;
            n = 0;
            while (qc.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
            if (n >= 100) check_val("c_drain_timeout", qc.size(), 0);
        end
        r8 = 1'b0;

        check_val("qa_left", qa.size(), 0);
        check_val("qb_left", qb.size(), 0);
        check_val("qc_left", qc.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
